pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and fetch sequencer for the single-cycle core: holds the architectural PC, drives the instruction-memory request handshake, and closes the loop from the ALU back to the PC. The ALU result, used as the jal/branch/jalr target, returns here and becomes the next PC, which is then fed forward on `pc_out` to the ALU operand select. It also computes the link value `pc+4` and traps misaligned control-flow targets.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, PC loaded on reset
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on misaligned target

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `alu_res` in 32: ALU result, used as the target address
- `branch` in 1: decoded branch instruction
- `br_taken` in 1: branch comparator result
- `jal` in 1: decoded jal
- `jalr` in 1: decoded jalr
- `stall` in 1: hold current instruction in EXEC
- `imem_ready` in 1: instruction memory accepts/returns fetch
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address, equals `pc_out`
- `pc_out` out 32: current PC, to the ALU operand select
- `pc_plus4` out 32: `pc_out + 4`, link value
- `instr_valid` out 1: instruction is executing this cycle
- `misalign_err` out 1: one-cycle trap pulse
- `err_addr` out 32: offending target address

## Operation
- The FSM has three states: IDLE, FETCH and EXEC.
- **IDLE:** entered only by reset. Moves to FETCH on the next edge with `rst_n` high.
- **FETCH:** `imem_req=1`. Stays in FETCH until `imem_ready` is sampled high at a posedge, then moves to EXEC.
- **EXEC:** `instr_valid=1`.
  - If `stall=1`: stay in EXEC and hold the PC.
  - If `stall=0`: load `pc <= next_pc` and return to FETCH.
- `next_pc` selection, highest priority first:
  - `jalr`: target `{alu_res[31:1],1'b0}`
  - `jal`: target `alu_res`
  - `branch & br_taken`: target `alu_res`
  - otherwise: `pc+4`
- Misalignment: a target with bit 1 set (after the jalr bit-0 clear) is misaligned.
  - The PC loads `TRAP_VECTOR` instead of the target.
  - `misalign_err=1` for exactly the cycle after the update.
  - `err_addr` is loaded with the unaligned target and holds until the next trap.
- The sequential `pc+4` path never traps.
- Arithmetic is modulo 2^32: `0xFFFF_FFFC + 4 = 0x0000_0000`.
- Decode inputs, `stall` and `alu_res` are ignored outside EXEC.
- `imem_ready` is ignored outside FETCH.

## Timing
- Reset: `rst_n` low at a posedge gives, from that edge:
  - state = IDLE, `pc_out = RESET_VECTOR`
  - `imem_req`, `instr_valid`, `misalign_err` = 0; `err_addr` = 0
  - This applies in any state, including mid-FETCH; `imem_req` drops at that edge.
- `imem_req` and `instr_valid` are Moore outputs decoded from the state register.
- `imem_addr`, `pc_out` and `pc_plus4` are combinational from the PC register.
- Minimum 2 cycles per instruction: one FETCH cycle with ready already high, plus one EXEC cycle. Each FETCH wait cycle adds one.
- `pc_out` changes only on the EXEC→FETCH edge, or on reset.
- Under stall: `instr_valid` stays high and the PC is held. Exactly one PC update occurs, on the first edge with `stall=0`.
- Simultaneous `jal` and `branch`/`br_taken`: `jal` wins.
- Simultaneous `jalr` and `jal`: `jalr` wins.

## Structure
- Shared package `pc_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_FETCH`, `ST_EXEC`)
  - default vector constants
  - the 32-bit width constant
- Sub-module `pc_next_sel` is combinational:
  - inputs: `pc`, `alu_res`, decode bits
  - outputs: `next_pc`, `misaligned`, `raw_target`
- The top level holds the FSM, the PC and the error registers.

## Test plan
- Reset and first fetch: `rst_n` low 2 cycles → `pc_out=0`, `imem_req=0`, `instr_valid=0`. After release, `imem_req=1` and `imem_addr=0` one cycle later.
- Sequential fetch, `imem_ready` with 0 then 2 wait cycles → `imem_addr` goes 0, 4, 8; `instr_valid` is a single-cycle pulse per instruction.
- Branch in EXEC at pc=0x8, `alu_res=0x40`:
  - `branch=1`, `br_taken=1` → next `imem_addr=0x40`.
  - Same with `br_taken=0` → 0xC.
  - `jal=1`, `branch=1`, `br_taken=1`, `alu_res=0x80` → 0x80.
- Jump alignment:
  - `jalr`, `alu_res=0x101` → pc=0x100, no error.
  - `jal`, `alu_res=0x102` → pc=0x100 (TRAP_VECTOR), `misalign_err` high one cycle, `err_addr=0x102`.
- Stall: `stall=1` for 3 cycles in EXEC at pc=0x20 → `instr_valid` high 4 cycles, pc held at 0x20, then 0x24.
- Corner cases:
  - `rst_n` low during FETCH with `imem_ready=0` → `imem_req` low at that edge, `pc_out=RESET_VECTOR`.
  - pc=0xFFFF_FFFC sequential → 0x0000_0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / fetch sequencer slice.
// Pure declarations, no timing.
// No handshakes here.
package pc_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // Control-flow targets must be word aligned; bit 0 is tolerated because
  // jalr clears it and the other paths never produce it from valid code.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundles the decode/ALU inputs and the fetch/PC outputs of pc_fetch_unit.
// No logic, no latency.
// imem_req/imem_ready form a valid-ready style fetch handshake.
interface pc_fetch_unit_if;
  import pc_pkg::*;

  logic [XLEN-1:0] alu_res;
  logic            branch;
  logic            br_taken;
  logic            jal;
  logic            jalr;
  logic            stall;
  logic            imem_ready;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic            instr_valid;
  logic            misalign_err;
  logic [XLEN-1:0] err_addr;

  // Core side: drives decode/ALU results, consumes PC and fetch request.
  modport master (
    output alu_res, branch, br_taken, jal, jalr, stall, imem_ready,
    input  imem_req, imem_addr, pc_out, pc_plus4, instr_valid,
           misalign_err, err_addr
  );

  // Fetch unit side.
  modport slave (
    input  alu_res, branch, br_taken, jal, jalr, stall, imem_ready,
    output imem_req, imem_addr, pc_out, pc_plus4, instr_valid,
           misalign_err, err_addr
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC selection: jalr > jal > taken branch > pc+4, with alignment trap.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to load the result.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_res,
  input  logic            branch,
  input  logic            br_taken,
  input  logic            jal,
  input  logic            jalr,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned,
  output logic [XLEN-1:0] raw_target
);

  logic take;

  // Pick the redirect target by priority; the sequential path never traps.
  always_comb begin
    raw_target = alu_res;
    take       = 1'b0;
    misaligned = 1'b0;
    next_pc    = pc + 32'd4;
    if (jalr) begin
      raw_target = {alu_res[XLEN-1:1], 1'b0};
      take       = 1'b1;
    end else if (jal || (branch && br_taken)) begin
      take       = 1'b1;
    end
    if (take) begin
      misaligned = is_misaligned(raw_target);
      next_pc    = misaligned ? TRAP_VECTOR : raw_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus IDLE/FETCH/EXEC sequencer closing the ALU-to-PC loop.
// Min 2 cycles/instr: 1 FETCH (ready high) + 1 EXEC; each FETCH wait adds one.
// Waits in FETCH while imem_ready is low; holds the PC in EXEC while stall is high.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input logic           clk,
  input logic           rst_n,
  pc_fetch_unit_if.slave bus
);

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] raw_target;
  logic            misaligned;
  logic            pc_load;
  logic            misalign_err;
  logic [XLEN-1:0] err_addr;
  logic            imem_req;
  logic            instr_valid;

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_sel (
    .pc         (pc),
    .alu_res    (bus.alu_res),
    .branch     (bus.branch),
    .br_taken   (bus.br_taken),
    .jal        (bus.jal),
    .jalr       (bus.jalr),
    .next_pc    (next_pc),
    .misaligned (misaligned),
    .raw_target (raw_target)
  );

  // The PC only advances on the EXEC->FETCH edge.
  assign pc_load = (state == ST_EXEC) && !bus.stall;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and Moore outputs decoded from the state register.
  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (!bus.stall) begin
          next_state = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Architectural PC: reset vector, then the selected next PC per instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (pc_load) begin
      pc <= next_pc;
    end
  end

  // Trap reporting: one-cycle pulse after the update, sticky faulting address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      misalign_err <= pc_load && misaligned;
      if (pc_load && misaligned) begin
        err_addr <= raw_target;
      end
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.instr_valid  = instr_valid;
  assign bus.imem_addr    = pc;
  assign bus.pc_out       = pc;
  assign bus.pc_plus4     = pc + 32'd4;
  assign bus.misalign_err = misalign_err;
  assign bus.err_addr     = err_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized checks of pc_fetch_unit against a transaction-level model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Fetch waits and stalls are driven from the bench.
module tb_pc_fetch_unit;
  import pc_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] exp_pc;
  logic [31:0] exp_err;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the next PC must be after one instruction, from the rules.
  function automatic void ref_step(input logic [31:0] pc, input logic [31:0] alu,
                                   input bit br, input bit tk, input bit j, input bit jr,
                                   output logic [31:0] npc, output bit trap,
                                   output logic [31:0] tgt);
    trap = 1'b0;
    tgt  = alu;
    npc  = pc + 32'd4;
    if (jr) tgt = alu & 32'hFFFF_FFFE;
    else if (!(j || (br && tk))) return;
    if ((tgt % 4) >= 2) begin
      trap = 1'b1;
      npc  = TV;
    end else begin
      npc = tgt;
    end
  endfunction

  task automatic rand_decode();
    bus.alu_res  = $urandom;
    bus.branch   = 1'($urandom_range(0, 1));
    bus.br_taken = 1'($urandom_range(0, 1));
    bus.jal      = 1'($urandom_range(0, 1));
    bus.jalr     = 1'($urandom_range(0, 1));
    bus.stall    = 1'($urandom_range(0, 1));
  endtask

  // Entered in FETCH; leaves in EXEC. Decode/stall are noise here.
  task automatic fetch(input int waits);
    chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ready = 1'b0;
      rand_decode();
      tick();
      chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
      chk("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("wait_addr", bus.imem_addr, exp_pc);
      chk("wait_err", {31'd0, bus.misalign_err}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    rand_decode();
    tick();
    chk("exec_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("exec_req", {31'd0, bus.imem_req}, 32'd0);
    chk("exec_pc", bus.pc_out, exp_pc);
    chk("exec_err", {31'd0, bus.misalign_err}, 32'd0);
  endtask

  // Entered in EXEC; leaves in FETCH. imem_ready is noise here.
  task automatic exec(input logic [31:0] alu, input bit br, input bit tk,
                      input bit j, input bit jr, input int stalls);
    logic [31:0] npc;
    logic [31:0] tgt;
    bit          trap;
    for (int i = 0; i < stalls; i++) begin
      rand_decode();
      bus.stall      = 1'b1;
      bus.imem_ready = 1'($urandom_range(0, 1));
      tick();
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("stall_pc", bus.pc_out, exp_pc);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.alu_res    = alu;
    bus.branch     = br;
    bus.br_taken   = tk;
    bus.jal        = j;
    bus.jalr       = jr;
    bus.stall      = 1'b0;
    bus.imem_ready = 1'($urandom_range(0, 1));
    tick();
    ref_step(exp_pc, alu, br, tk, j, jr, npc, trap, tgt);
    exp_pc = npc;
    if (trap) exp_err = tgt;
    chk("upd_pc", bus.pc_out, exp_pc);
    chk("upd_addr", bus.imem_addr, exp_pc);
    chk("upd_plus4", bus.pc_plus4, exp_pc + 32'd4);
    chk("upd_req", {31'd0, bus.imem_req}, 32'd1);
    chk("upd_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("upd_trap", {31'd0, bus.misalign_err}, {31'd0, trap});
    chk("upd_err_addr", bus.err_addr, exp_err);
    bus.imem_ready = 1'b0;
  endtask

  task automatic instr(input logic [31:0] alu, input bit br, input bit tk,
                       input bit j, input bit jr, input int waits, input int stalls);
    fetch(waits);
    exec(alu, br, tk, j, jr, stalls);
  endtask

  initial begin
    logic [31:0] a;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.alu_res = '0; bus.branch = 1'b0; bus.br_taken = 1'b0;
    bus.jal = 1'b0; bus.jalr = 1'b0; bus.stall = 1'b0; bus.imem_ready = 1'b0;
    exp_pc  = RV;
    exp_err = '0;

    // Reset held two cycles.
    tick();
    tick();
    chk("rst_pc", bus.pc_out, RV);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, bus.misalign_err}, 32'd0);
    chk("rst_err_addr", bus.err_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Sequential fetches, 0 then 2 wait cycles: 0 -> 4 -> 8.
    instr(32'h0, 0, 0, 0, 0, 0, 0);
    instr(32'h0, 0, 0, 0, 0, 2, 0);
    chk("seq_at_8", bus.imem_addr, 32'h8);

    // Branches at pc 0x8.
    instr(32'h40, 1, 1, 0, 0, 0, 0);
    chk("br_taken", bus.imem_addr, 32'h40);
    instr(32'h8, 0, 0, 1, 0, 0, 0);
    instr(32'h40, 1, 0, 0, 0, 0, 0);
    chk("br_not_taken", bus.imem_addr, 32'hC);
    instr(32'h80, 1, 1, 1, 0, 0, 0);
    chk("jal_over_br", bus.imem_addr, 32'h80);
    instr(32'h204, 0, 0, 1, 1, 0, 0);
    chk("jalr_over_jal", bus.imem_addr, 32'h204);

    // Alignment.
    instr(32'h101, 0, 0, 0, 1, 1, 0);
    chk("jalr_clear_b0", bus.pc_out, 32'h100);
    chk("jalr_no_trap", {31'd0, bus.misalign_err}, 32'd0);
    instr(32'h102, 0, 0, 1, 0, 0, 0);
    chk("jal_trap_pc", bus.pc_out, TV);
    chk("jal_trap_addr", bus.err_addr, 32'h102);

    // Stall three cycles at 0x20.
    instr(32'h20, 0, 0, 1, 0, 0, 0);
    instr(32'h0, 0, 0, 0, 0, 0, 3);
    chk("after_stall", bus.pc_out, 32'h24);
    chk("err_addr_sticky", bus.err_addr, 32'h102);

    // Wrap at the top of the address space.
    instr(32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0);
    instr(32'h0, 0, 0, 0, 0, 0, 0);
    chk("wrap", bus.pc_out, 32'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'($urandom_range(0, 1));
      instr(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Force a known trap so err_addr is nonzero before the mid-fetch reset.
    instr(32'h0000_0806, 0, 0, 1, 0, 0, 0);
    chk("pre_rst_err", bus.err_addr, 32'h806);

    // Reset while FETCH waits on memory.
    bus.imem_ready = 1'b0;
    tick();
    chk("midf_req_before", {31'd0, bus.imem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midf_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midf_pc", bus.pc_out, RV);
    chk("midf_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("midf_err_addr", bus.err_addr, 32'd0);
    rst_n  = 1'b1;
    exp_pc = RV;
    tick();
    chk("midf_refetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("midf_refetch_addr", bus.imem_addr, RV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
